// File: rtl/data_sram_responder_if.sv
// CPU data-port request/response bundle for the SRAM responder.
// The master drives requests; the slave returns rdata, ack and busy.
interface data_sram_responder_if;
    logic        req_en;
    logic [3:0]  req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;

    modport master (
        output req_en, req_wen, req_addr, req_wdata,
        input  rdata, ack, busy
    );

    modport slave (
        input  req_en, req_wen, req_addr, req_wdata,
        output rdata, ack, busy
    );
endinterface

// File: rtl/data_sram_responder.sv
// Fixed-latency SRAM responder for a CPU data port.
// Writes commit at acceptance; reads snapshot the word at acceptance and return it on ack.
module data_sram_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input logic                  clk,
    input logic                  rst,
    data_sram_responder_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [2:0]  LOAD  = 3'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state;
    logic [2:0]          count;
    logic [31:0]         mem [DEPTH];
    logic [31:0]         rd_word;
    logic                is_read;
    logic [ADDR_W-1:0]   idx;
    logic                accept;

    assign idx    = bus.req_addr[ADDR_W+1:2];
    assign accept = bus.req_en & ~bus.busy & ~rst;

    // Memory has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_wen[i]) begin
                    mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            count     <= 3'd0;
            bus.ack   <= 1'b0;
            bus.busy  <= 1'b0;
            bus.rdata <= 32'h0;
        end else begin
            bus.ack  <= 1'b0;
            bus.busy <= 1'b0;
            unique case (state)
                StIdle, StResp: begin
                    if (accept) begin
                        is_read <= (bus.req_wen == 4'b0000);
                        rd_word <= mem[idx];
                        if (LATENCY == 1) begin
                            state   <= StResp;
                            bus.ack <= 1'b1;
                            if (bus.req_wen == 4'b0000) begin
                                bus.rdata <= mem[idx];
                            end
                        end else begin
                            state    <= StWait;
                            count    <= LOAD;
                            bus.busy <= 1'b1;
                        end
                    end else begin
                        state <= StIdle;
                    end
                end
                StWait: begin
                    if (count <= 3'd1) begin
                        state   <= StResp;
                        count   <= 3'd0;
                        bus.ack <= 1'b1;
                        if (is_read) begin
                            bus.rdata <= rd_word;
                        end
                    end else begin
                        count    <= count - 3'd1;
                        bus.busy <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Drives four responders (LATENCY 2,3,1,4) with shared stimulus and checks each
// against a time-based model: accept at T, busy T+1..T+L-1, ack and data at T+L.
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_en;
    logic [3:0]  req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  ack_v;
    logic [3:0]  busy_v;
    logic [31:0] rdata_v [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 1 : 4;
        data_sram_responder_if bus ();
        assign bus.req_en    = req_en;
        assign bus.req_wen   = req_wen;
        assign bus.req_addr  = req_addr;
        assign bus.req_wdata = req_wdata;
        assign ack_v[g]      = bus.ack;
        assign busy_v[g]     = bus.busy;
        assign rdata_v[g]    = bus.rdata;
        data_sram_responder #(.ADDR_W(10), .LATENCY(L)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    // Reference model state, one slot per instance.
    int          lat [4] = '{2, 3, 1, 4};
    logic [31:0] mmem [4][1024];
    longint      ack_at [4];
    bit          pend_rd [4];
    logic [31:0] pend_data [4];
    logic [31:0] exp_rd [4];
    int          ack_cnt [4];
    longint      cyc;
    bit          armed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs of the current cycle, apply inputs, advance model.
    task automatic step(input bit en, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit r);
        for (int g = 0; g < 4; g++) begin
            if (armed) begin
                if (ack_at[g] == cyc && pend_rd[g]) exp_rd[g] = pend_data[g];
                chk($sformatf("ack[%0d]@%0d", g, cyc), {31'b0, ack_v[g]},
                    {31'b0, ack_at[g] == cyc});
                chk($sformatf("busy[%0d]@%0d", g, cyc), {31'b0, busy_v[g]},
                    {31'b0, ack_at[g] > cyc});
                chk($sformatf("rdata[%0d]@%0d", g, cyc), rdata_v[g], exp_rd[g]);
            end
            if (ack_v[g] === 1'b1) ack_cnt[g]++;
        end
        rst       = r;
        req_en    = en;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        for (int g = 0; g < 4; g++) begin
            if (r) begin
                ack_at[g] = -1;
                exp_rd[g] = 32'h0;
            end else if (en && !(ack_at[g] > cyc)) begin
                if (wen == 4'b0000) begin
                    pend_rd[g]   = 1'b1;
                    pend_data[g] = mmem[g][addr[11:2]];
                end else begin
                    pend_rd[g] = 1'b0;
                    for (int b = 0; b < 4; b++)
                        if (wen[b]) mmem[g][addr[11:2]][8*b +: 8] = wdata[8*b +: 8];
                end
                ack_at[g] = cyc + lat[g];
            end
        end
        if (r) armed = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        int base;
        logic [31:0] a;
        cyc   = 0;
        armed = 1'b0;
        for (int g = 0; g < 4; g++) begin
            ack_at[g]  = -1;
            pend_rd[g] = 1'b0;
            exp_rd[g]  = 32'h0;
            ack_cnt[g] = 0;
        end
        @(negedge clk);
        step(1'b1, 4'hF, 32'h0, 32'h0, 1'b1);
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("reset_ack[%0d]", g), {31'b0, ack_v[g]}, 32'h0);
            chk($sformatf("reset_busy[%0d]", g), {31'b0, busy_v[g]}, 32'h0);
            chk($sformatf("reset_rdata[%0d]", g), rdata_v[g], 32'h0);
        end

        // Preload words 0..15 so every later read has a known value.
        for (int w = 0; w < 16; w++) begin
            step(1'b1, 4'hF, 32'(w * 4), $urandom, 1'b0);
            idle(4);
        end

        // Full-word write then read.
        step(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
        idle(4);
        step(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
        idle(4);
        for (int g = 0; g < 4; g++) chk($sformatf("fullword[%0d]", g), rdata_v[g], 32'hDEADBEEF);

        // Single byte lane.
        step(1'b1, 4'b0010, 32'h10, 32'h0000AA00, 1'b0);
        idle(4);
        step(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
        idle(4);
        for (int g = 0; g < 4; g++) chk($sformatf("bytelane[%0d]", g), rdata_v[g], 32'hDEADAAEF);

        // Requests held while the LATENCY=3 instance is busy.
        step(1'b1, 4'hF, 32'h20, 32'h0BADF00D, 1'b0);
        idle(4);
        base = ack_cnt[1];
        step(1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
        step(1'b1, 4'hF, 32'h20, 32'hFFFFFFFF, 1'b0);
        step(1'b1, 4'hF, 32'h20, 32'hFFFFFFFF, 1'b0);
        idle(4);
        chk("busy_ignore_acks", 32'(ack_cnt[1] - base), 32'd1);
        step(1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
        idle(4);
        chk("busy_ignore_mem", rdata_v[1], 32'h0BADF00D);

        // Back-to-back reads; the LATENCY=1 instance takes all three.
        step(1'b1, 4'h0, 32'h0, 32'h0, 1'b0);
        step(1'b1, 4'h0, 32'h4, 32'h0, 1'b0);
        step(1'b1, 4'h0, 32'h8, 32'h0, 1'b0);
        idle(4);

        // Reset two cycles after a write on the LATENCY=4 instance.
        base = ack_cnt[3];
        step(1'b1, 4'hF, 32'h30, 32'h55AA55AA, 1'b0);
        idle(1);
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("midreset_busy", {31'b0, busy_v[3]}, 32'h0);
        chk("midreset_rdata", rdata_v[3], 32'h0);
        idle(4);
        chk("midreset_noack", 32'(ack_cnt[3] - base), 32'd0);
        step(1'b1, 4'h0, 32'h30, 32'h0, 1'b0);
        idle(5);
        chk("midreset_mem", rdata_v[3], 32'h55AA55AA);

        // Address aliasing modulo 1024 words.
        step(1'b1, 4'hF, 32'h1004, 32'h12345678, 1'b0);
        idle(4);
        step(1'b1, 4'h0, 32'h0004, 32'h0, 1'b0);
        idle(4);
        for (int g = 0; g < 4; g++) chk($sformatf("alias[%0d]", g), rdata_v[g], 32'h12345678);

        // Random traffic over the preloaded words, with aliasing and occasional reset.
        for (int i = 0; i < 400; i++) begin
            a       = $urandom;
            a[11:6] = 6'd0;
            step($urandom_range(0, 9) < 6,
                 ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom),
                 a, $urandom, $urandom_range(0, 49) == 0);
        end
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width; the memory depth is 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to ack; the legal range is 1..7.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_en  input  1  request strobe from the CPU data port.
REQ-006 SHALL have port req_wen  input  4  byte-lane write enables, bit i for data[8i+7:8i]; 4'b0000 marks a read.
REQ-007 SHALL have port req_addr  input  32  byte address; only bits [ADDR_W+1:2] are used.
REQ-008 SHALL have port req_wdata  input  32  store data, already lane-aligned by the requester.
REQ-009 SHALL have port rdata  output  32  read data, valid in the ack cycle of a read.
REQ-010 SHALL have port ack  output  1  one-cycle completion pulse for both reads and writes.
REQ-011 SHALL have port busy  output  1  responder occupied; used directly as the pipeline stall request.

Function
REQ-012 SHALL implement an FSM with three states:
- IDLE: no request in flight.
- WAIT: a request is in flight and the latency counter is running.
- RESP: the ack cycle.
REQ-013 SHALL accept a request in cycle T when req_en=1 and busy=0; if busy=1, req_en SHALL be ignored, with no queuing and no memory side effects.
REQ-014 SHALL commit a write at the end of the acceptance cycle T, updating only the lanes whose req_wen bits are set; unselected lanes SHALL keep their previous bytes.
REQ-015 SHALL capture read data for a read as the word at the accepted address at the end of cycle T; writes accepted later SHALL NOT alter it.
REQ-016 SHALL drive busy=1 in cycles T+1 .. T+LATENCY-1 and busy=0 in the ack cycle T+LATENCY; with LATENCY=1, busy SHALL never assert.
REQ-017 SHALL drive ack=1 only in cycle T+LATENCY, for exactly one cycle per accepted request.
REQ-018 SHALL, in a read's ack cycle, drive rdata with the captured word; in all other cycles rdata SHALL hold its last value.
REQ-019 SHALL accept a new request in the ack cycle (busy=0 there), giving back-to-back throughput of one request per LATENCY cycles.
REQ-020 SHALL use a 3-bit latency down-counter, loaded at acceptance, with no wrap-around past zero.
- LATENCY=1: transition IDLE->RESP.
- Otherwise: transition IDLE->WAIT->RESP.
- From RESP: go to IDLE, or restart the sequence if a new request is accepted.
REQ-021 SHALL return, for a read of an address written by an earlier accepted write, the post-write data, including a read accepted in that write's ack cycle.
REQ-022 SHALL ignore req_addr bits above ADDR_W+1; the address aliases modulo the memory depth.
REQ-023 SHALL ignore req_addr[1:0]; no misalignment checking is performed.

Reset
REQ-024 SHALL, with rst=1 at a rising edge, force state=IDLE, counter=0, ack=0, busy=0 and rdata=32'h0.
REQ-025 SHALL treat reset mid-operation as follows:
- the in-flight request is dropped and no ack is issued;
- a write already committed at acceptance remains in memory.
REQ-026 SHALL NOT clear or initialise memory contents on reset.
REQ-027 SHALL ignore req_en in any cycle where rst=1.

Verification
REQ-028 Full-word write and read back (LATENCY=2):
- stimulus: write addr 0x10, wen 4'b1111, data 0xDEADBEEF; then read 0x10;
- response: busy high for 1 cycle after each request; ack at T+2; rdata 0xDEADBEEF.
REQ-029 Byte-lane write (word 0x10 = 0xDEADBEEF):
- stimulus: write wen 4'b0010, data 0x0000AA00; then read 0x10;
- response: rdata 0xDEADAAEF.
REQ-030 Request during busy (LATENCY=3):
- stimulus: req_en held high with a write to 0x20 while busy=1;
- response: no memory change and exactly one ack, for the original request.
REQ-031 Back-to-back at LATENCY=1:
- stimulus: reads of 0x0, 0x4 and 0x8 on consecutive cycles;
- response: busy never asserts; acks on three consecutive cycles with the matching data in order.
REQ-032 Reset mid-operation (LATENCY=4):
- stimulus: write 0x55AA55AA to 0x30; assert rst at T+2;
- response: no ack; busy=0 and rdata=0 the next cycle; a later read of 0x30 returns 0x55AA55AA.
REQ-033 Address aliasing (ADDR_W=10):
- stimulus: write 0x12345678 to 0x1004; then read 0x0004;
- response: rdata 0x12345678.
